vending_machine: RTL and testbench
==================================

# vending_machine

Synchronous candy vending controller. It accepts nickel (5¢), dime (10¢) and quarter (25¢) coin pulses and accumulates credit toward a 15¢ candy. It dispenses the candy with exact change in nickels and dimes, or refunds the held credit on request. It is a leaf block driven by a coin-acceptor front end and drives the dispenser and change-hopper actuators.

## Interface
- No parameters. Price 15¢ and coin values are fixed constants.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-high reset. The name is kept for codebase consistency; asserting it high resets on the next rising edge.
- `nickel_in` in 1: a 5¢ coin is present this cycle.
- `dime_in` in 1: a 10¢ coin is present this cycle.
- `quarter_in` in 1: a 25¢ coin is present this cycle.
- `thanks_in` in 1: refund request; returns held credit without vending.
- `candy_out` out 1: dispense one candy (one-cycle pulse).
- `nickel_out` out 1: eject one nickel (one-cycle pulse).
- `dime_out` out 2: number of dimes to eject, 0–2 (one-cycle value).

## Operation
- Credit states: S0 (0¢), S5 (5¢), S10 (10¢).
- Inputs are sampled every rising edge. A level held for k cycles counts as k coins.
- Coin priority when several are high in one cycle: quarter > dime > nickel; the lower-priority coins are ignored.
- Any coin has priority over `thanks_in` in the same cycle; `thanks_in` is then ignored.
- Transitions and outputs, written as coin: next state / outputs. Outputs not listed are 0.
  - S0 nickel: S5. S0 dime: S10. S0 quarter: S0 / candy=1, dime_out=1.
  - S5 nickel: S10. S5 dime: S0 / candy=1. S5 quarter: S0 / candy=1, nickel=1, dime_out=1.
  - S10 nickel: S0 / candy=1. S10 dime: S0 / candy=1, nickel=1. S10 quarter: S0 / candy=1, dime_out=2.
  - `thanks_in` with no coin: S5 → S0 / nickel=1. S10 → S0 / dime_out=1. S0 → S0 / no output.
  - No input: hold state, all outputs 0.
- Invariant: coins in = 15¢ × candies + change + credit. Change is always the minimum coin count, preferring dimes.

## Timing
- Outputs are registered. For a coin sampled at edge N, the outputs are valid from edge N until edge N+1, then return to 0 unless the next input produces a new output.
- Back-to-back purchases in consecutive cycles are legal; each produces its own one-cycle output pulse.
- Reset: state=S0, `candy_out`=0, `nickel_out`=0, `dime_out`=2'b00 after the rising edge where `rst_n`=1.
- Reset has priority over all inputs. Reset during accumulation discards credit with no refund and no output.
- No handshake with the actuators. Downstream must capture the one-cycle pulses.

## Structure
- Shared package `vending_pkg` holds:
  - State enum {S0, S5, S10} (2-bit encoding).
  - Constants PRICE=15, NICKEL=5, DIME=10, QUARTER=25.
- Single module with one state register, one output register set and one combinational next-state/output block. No sub-module is needed.

## Test plan
- Reset: `rst_n`=1 for one edge after arbitrary credit → state S0, all outputs 0 for every following idle cycle.
- No coins for 4 cycles → `candy_out`=0, `nickel_out`=0, `dime_out`=0 throughout.
- dime, idle 3 cycles, dime → one-cycle pulse `candy_out`=1, `nickel_out`=1, `dime_out`=0, then all outputs 0. Follow with a quarter → `candy_out`=1, `dime_out`=1.
- Per starting state, quarter from S0/S5/S10 → `dime_out`=1/1/2, `nickel_out`=0/1/0, `candy_out`=1 each time, ending in S0.
- Three nickels → pulse `candy_out`=1 only on the third coin. Nickel then `thanks_in` → `nickel_out`=1, `candy_out`=0. Two nickels then `thanks_in` → `dime_out`=1.
- Simultaneous inputs: `nickel_in`+`quarter_in`+`thanks_in` high in S0 → treated as a quarter only: `candy_out`=1, `dime_out`=1. Reset asserted in the same cycle as a dime in S5 → S0, no outputs.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and coin constants for the candy vending controller.
// Credit is tracked as one of three states; all arithmetic is in cents.
package vending_pkg;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2
    } state_t;

    localparam logic [5:0] PRICE   = 6'd15;
    localparam logic [5:0] NICKEL  = 6'd5;
    localparam logic [5:0] DIME    = 6'd10;
    localparam logic [5:0] QUARTER = 6'd25;

    function automatic logic [5:0] credit_of(input state_t s);
        logic [5:0] c;
        case (s)
            S5:      c = 6'd5;
            S10:     c = 6'd10;
            default: c = 6'd0;
        endcase
        return c;
    endfunction

    // Only 0, 5 and 10 cents can be held below the price.
    function automatic state_t state_of(input logic [5:0] cents);
        state_t s;
        case (cents)
            6'd5:    s = S5;
            6'd10:   s = S10;
            default: s = S0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vending_machine.sv
// Candy vending controller: accumulates coin credit toward a 15 cent candy,
// vends with minimum change (dimes first) and refunds on request.
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       quarter_in,
    input  logic       thanks_in,
    output logic       candy_out,
    output logic       nickel_out,
    output logic [1:0] dime_out
);

    state_t     state_q, state_d;
    logic       candy_q, candy_d;
    logic       nickel_q, nickel_d;
    logic [1:0] dime_q, dime_d;

    logic [5:0] coin_value;
    logic [5:0] total;
    logic [5:0] change;

    always_ff @(posedge clk) begin
        // rst_n is active-high despite its name.
        if (rst_n) begin
            state_q  <= S0;
            candy_q  <= 1'b0;
            nickel_q <= 1'b0;
            dime_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            candy_q  <= candy_d;
            nickel_q <= nickel_d;
            dime_q   <= dime_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        candy_d    = 1'b0;
        nickel_d   = 1'b0;
        dime_d     = 2'b00;
        coin_value = 6'd0;
        total      = 6'd0;
        change     = 6'd0;

        if (quarter_in) begin
            coin_value = QUARTER;
        end else if (dime_in) begin
            coin_value = DIME;
        end else if (nickel_in) begin
            coin_value = NICKEL;
        end

        if (coin_value != 6'd0) begin
            total = credit_of(state_q) + coin_value;
            if (total >= PRICE) begin
                state_d = S0;
                candy_d = 1'b1;
                change  = total - PRICE;
                // Change is at most 20 cents: greedy dimes, then one nickel.
                if (change >= 6'd20) begin
                    dime_d = 2'd2;
                    change = change - 6'd20;
                end else if (change >= 6'd10) begin
                    dime_d = 2'd1;
                    change = change - 6'd10;
                end
                nickel_d = (change != 6'd0);
            end else begin
                state_d = state_of(total);
            end
        end else if (thanks_in) begin
            state_d  = S0;
            nickel_d = (state_q == S5);
            dime_d   = (state_q == S10) ? 2'd1 : 2'd0;
        end
    end

    assign candy_out  = candy_q;
    assign nickel_out = nickel_q;
    assign dime_out   = dime_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed scoreboard bench for vending_machine: expected outputs are queued
// when each input cycle is driven and compared after the corresponding edge.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nickel_in = 1'b0;
    logic       dime_in = 1'b0;
    logic       quarter_in = 1'b0;
    logic       thanks_in = 1'b0;
    logic       candy_out;
    logic       nickel_out;
    logic [1:0] dime_out;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    vending_machine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nickel_in (nickel_in),
        .dime_in   (dime_in),
        .quarter_in(quarter_in),
        .thanks_in (thanks_in),
        .candy_out (candy_out),
        .nickel_out(nickel_out),
        .dime_out  (dime_out)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs, push expectation {candy, nickel, dime[1:0]},
    // clock, then pop and compare against the registered outputs.
    task automatic step(input logic r, input logic n, input logic d,
                        input logic q, input logic t,
                        input logic ec, input logic en, input logic [1:0] ed,
                        input string tag);
        logic [3:0] expected;
        logic [3:0] observed;
        @(negedge clk);
        rst_n      = r;
        nickel_in  = n;
        dime_in    = d;
        quarter_in = q;
        thanks_in  = t;
        exp_q.push_back({ec, en, ed});
        @(posedge clk);
        #1;
        expected = exp_q.pop_front();
        observed = {candy_out, nickel_out, dime_out};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed candy=%0b nickel=%0b dime=%0d expected candy=%0b nickel=%0b dime=%0d",
                   tag, observed[3], observed[2], observed[1:0],
                   expected[3], expected[2], expected[1:0]);
        end
        $display("step %-14s rst=%0b n=%0b d=%0b q=%0b t=%0b -> candy=%0b nickel=%0b dime=%0d",
                 tag, r, n, d, q, t, observed[3], observed[2], observed[1:0]);
    endtask

    initial begin
        //    rst n d q t   c n dime
        step(1, 0, 0, 0, 0, 0, 0, 2'd0, "reset");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 2'd0, "idle");

        // dime, idle x3, dime -> candy + nickel, then quiet, then a quarter
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, "dime_s0");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 2'd0, "hold_s10");
        step(0, 0, 1, 0, 0, 1, 1, 2'd0, "dime_s10");
        step(0, 0, 0, 0, 0, 0, 0, 2'd0, "pulse_end");
        step(0, 0, 0, 1, 0, 1, 0, 2'd1, "quarter_s0");

        // quarter from S5 and S10
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(0, 0, 0, 1, 0, 1, 1, 2'd1, "quarter_s5");
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, "dime_s0");
        step(0, 0, 0, 1, 0, 1, 0, 2'd2, "quarter_s10");
        step(0, 0, 0, 0, 0, 0, 0, 2'd0, "idle");

        // three nickels vend on the third only
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_1");
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_2");
        step(0, 1, 0, 0, 0, 1, 0, 2'd0, "nickel_3");

        // refunds
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(0, 0, 0, 0, 1, 0, 1, 2'd0, "thanks_s5");
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s5");
        step(0, 0, 0, 0, 1, 0, 0, 2'd1, "thanks_s10");
        step(0, 0, 0, 0, 1, 0, 0, 2'd0, "thanks_s0");

        // simultaneous nickel+quarter+thanks in S0 is a quarter only
        step(0, 1, 0, 1, 1, 1, 0, 2'd1, "n_q_t_s0");
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(0, 0, 0, 0, 1, 0, 1, 2'd0, "thanks_s5");

        // dime+nickel in S0 is a dime only; then nickel vends exactly
        step(0, 1, 1, 0, 0, 0, 0, 2'd0, "n_d_s0");
        step(0, 1, 0, 0, 0, 1, 0, 2'd0, "nickel_s10");

        // coin beats thanks in S5
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(0, 0, 1, 0, 1, 1, 0, 2'd0, "dime_thanks_s5");

        // reset with a dime in S5 discards credit
        step(0, 1, 0, 0, 0, 0, 0, 2'd0, "nickel_s0");
        step(1, 0, 1, 0, 0, 0, 0, 2'd0, "rst_dime_s5");
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, "dime_after_rst");
        step(0, 1, 0, 0, 0, 1, 0, 2'd0, "nickel_s10");

        // reset from S10 then idle; a dime alone must not vend
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, "dime_s0");
        step(1, 0, 0, 0, 0, 0, 0, 2'd0, "rst_s10");
        step(0, 0, 0, 0, 0, 0, 0, 2'd0, "idle_after_rst");
        step(0, 0, 0, 0, 0, 0, 0, 2'd0, "idle_after_rst");
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, "dime_s0");
        step(0, 0, 0, 0, 1, 0, 0, 2'd1, "thanks_s10");

        // back-to-back purchases, each with its own pulse
        step(0, 0, 0, 1, 0, 1, 0, 2'd1, "b2b_quarter_1");
        step(0, 0, 0, 1, 0, 1, 0, 2'd1, "b2b_quarter_2");
        step(0, 0, 0, 0, 0, 0, 0, 2'd0, "idle");

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
